spi_shift_engine: RTL and testbench
===================================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter WIDTH, default 16, shift register length in bits (legal 2..64).
REQ-002 Parameter CW, default $clog2(WIDTH)+1, width of frameLen.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 peripheralClkEdge  input  1  one-clk strobe marking one serial bit period.
REQ-006 parallelLoad  input  1  start request; loads a frame.
REQ-007 parallelDataIn  input  WIDTH  word to transmit, right-justified.
REQ-008 frameLen  input  CW  bits per frame, sampled at load.
REQ-009 msbFirst  input  1  1 = MSB-first, 0 = LSB-first, sampled at load.
REQ-010 serialDataIn  input  1  received serial bit.
REQ-011 serialDataOut  output  1  current transmit bit.
REQ-012 parallelDataOut  output  WIDTH  live register contents.
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  one-clk pulse at frame end.
REQ-015 rxAck, rxData (WIDTH), rxValid, rxOverrun  exist only with SHIFT_RX_HOLD_EN (see Configuration).

Function
REQ-016 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on parallelLoad; SHIFT->DONE on the edge shifting the last bit; DONE->IDLE after one clk, or DONE->SHIFT if parallelLoad that clk.
REQ-017 Load (IDLE or DONE): mem <= parallelDataIn with bits at or above the effective length cleared; latch length and direction; bit counter <= 0; busy high next clk.
REQ-018 Effective length: frameLen 0 or greater than WIDTH gives WIDTH; otherwise frameLen.
REQ-019 Active field is mem[len-1:0].
REQ-020 LSB-first edge: field shifts right by one; serialDataIn enters bit len-1; serialDataOut = mem[0].
REQ-021 MSB-first edge: field shifts left by one; serialDataIn enters bit 0; serialDataOut = mem[len-1].
REQ-022 Each shift increments the counter; the len-th edge moves to DONE; the received frame then sits right-justified in parallelDataOut, upper bits 0.
REQ-023 serialDataOut and parallelDataOut are combinational from registers; no added latency.
REQ-024 peripheralClkEdge in IDLE or DONE: no effect.
REQ-025 parallelLoad during SHIFT: ignored; no abort and no restart.
REQ-026 parallelLoad and peripheralClkEdge in the same clk: in IDLE/DONE the load wins and the edge is dropped; in SHIFT the edge is taken and the load ignored.
REQ-027 done is high only in DONE, exactly one clk per frame; busy is low in IDLE and DONE.

Reset
REQ-028 resetN low at any time, including mid-frame, immediately forces: state IDLE, mem 0, counter 0, length WIDTH, direction LSB-first, busy 0, done 0, serialDataOut 0, rxData 0, rxValid 0, rxOverrun 0.
REQ-029 A frame interrupted by reset is discarded; no done pulse is produced.

Configuration
REQ-030 Macro SHIFT_RX_HOLD_EN.
- Defined: in DONE, rxData <= mem and rxValid <= 1.
- Defined: if rxValid is already 1 and rxAck is not asserted that clk, rxOverrun <= 1 (sticky).
- Defined: rxAck clears rxValid and rxOverrun.
- Defined: rxAck coincident with DONE loads the new data, leaves rxValid 1 and does not set rxOverrun.
- Undefined: the four rx ports and their logic are absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=16, frameLen 16, msbFirst 0, load 0x00A5, serialDataIn=1 for 16 edges -> serialDataOut 1,0,1,0,0,1,0,1 then 0 x8; parallelDataOut 0xFFFF; single done pulse; busy low after.
REQ-032 frameLen 8, msbFirst 1, load 0x00B4, serial in 0,1,0,1,1,0,1,0 -> serialDataOut 1,0,1,1,0,1,0,0; parallelDataOut 0x005A after the 8th edge; done after 8 edges.
REQ-033 frameLen 0, then frameLen 20 -> each frame takes 16 edges before done.
REQ-034 parallelLoad asserted with an edge mid-SHIFT -> shift occurs, counter advances, mem not reloaded.
REQ-035 resetN pulsed low after 5 edges -> all outputs at reset values within the same clk; no done pulse; next load runs a full, normal frame.
REQ-036 SHIFT_RX_HOLD_EN: two 8-bit frames 0x5A then 0x3C, no rxAck -> rxData 0x3C, rxValid 1, rxOverrun 1; rxAck -> both flags 0.

Source files
------------

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// Purpose:
//   This is a serial shift engine for an SPI-style peripheral. Each frame is
//   loaded in parallel. It is then shifted one bit for every
//   peripheralClkEdge strobe. The frame can be LSB-first or MSB-first, and its
//   length can be set from 1 to WIDTH bits. The received bits build up in the
//   same register. At the end of the frame they sit right-justified in
//   parallelDataOut.
//
// Optional feature (macro SHIFT_RX_HOLD_EN):
//   When the macro is defined, a receive holding register is added. It
//   captures each completed frame. A valid flag and a sticky overrun flag go
//   with it. Both flags are cleared by rxAck. When the macro is undefined, the
//   rx ports and their logic are absent.
//
// Ports:
//   clk               single clock, rising-edge active
//   resetN            asynchronous active-low reset
//   peripheralClkEdge one-clk strobe per serial bit period
//   parallelLoad      start request (accepted in IDLE or DONE)
//   parallelDataIn    transmit word, right-justified
//   frameLen          bits per frame (0 or >WIDTH means WIDTH), sampled at load
//   msbFirst          1 = MSB-first, 0 = LSB-first, sampled at load
//   serialDataIn      received serial bit
//   rxAck             (SHIFT_RX_HOLD_EN) acknowledge of the held frame
//   rxData            (SHIFT_RX_HOLD_EN) held received frame
//   rxValid           (SHIFT_RX_HOLD_EN) held frame not yet acknowledged
//   rxOverrun         (SHIFT_RX_HOLD_EN) a frame arrived before the ack (sticky)
//   serialDataOut     current transmit bit
//   parallelDataOut   live shift register contents
//   busy              high while shifting
//   done              one-clk pulse at frame end
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic [CW-1:0]    frameLen,
    input  logic             msbFirst,
    input  logic             serialDataIn,
`ifdef SHIFT_RX_HOLD_EN
    input  logic             rxAck,
    output logic [WIDTH-1:0] rxData,
    output logic             rxValid,
    output logic             rxOverrun,
`endif
    output logic             serialDataOut,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0]    LEN_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LEN_FULL = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MEM_ZERO = {WIDTH{1'b0}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_q, len_d;
    logic             msb_q, msb_d;

    logic [CW-1:0]    eff_len_s;
    logic [CW-1:0]    len_m1_s;
    logic [WIDTH-1:0] load_mask_s;
    logic [WIDTH-1:0] msb_sel_s;
    logic [WIDTH-1:0] mem_sr_s;
    logic [WIDTH-1:0] mem_sl_s;
    logic [WIDTH-1:0] shift_lsb_s;
    logic [WIDTH-1:0] shift_msb_s;

    assign len_m1_s = len_q - LEN_ONE;
    assign mem_sr_s = {1'b0, mem_q[WIDTH-1:1]};
    assign mem_sl_s = {mem_q[WIDTH-2:0], 1'b0};

    // Clamp the requested frame length: zero or oversize selects the full register.
    always_comb begin
        if ((frameLen == {CW{1'b0}}) || (frameLen > LEN_FULL)) begin
            eff_len_s = LEN_FULL;
        end else begin
            eff_len_s = frameLen;
        end
    end

    // Per-bit load mask, MSB tap select and both shifted images of the active field.
    always_comb begin
        load_mask_s = MEM_ZERO;
        msb_sel_s   = MEM_ZERO;
        shift_lsb_s = MEM_ZERO;
        shift_msb_s = MEM_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            load_mask_s[i] = (CW'(i) < eff_len_s);
            msb_sel_s[i]   = (CW'(i) == len_m1_s);
            // Right shift inside the field: the top of the field takes the new bit.
            if (CW'(i) < len_m1_s) begin
                shift_lsb_s[i] = mem_sr_s[i];
            end else if (CW'(i) == len_m1_s) begin
                shift_lsb_s[i] = serialDataIn;
            end else begin
                shift_lsb_s[i] = 1'b0;
            end
            // Left shift inside the field: bit 0 takes the new bit, the field top is dropped.
            if (i == 0) begin
                shift_msb_s[i] = serialDataIn;
            end else if (CW'(i) < len_q) begin
                shift_msb_s[i] = mem_sl_s[i];
            end else begin
                shift_msb_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic for the frame FSM and the shift datapath.
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        msb_d   = msb_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A load here wins over any coincident edge, and that edge is dropped.
                if (parallelLoad) begin
                    mem_d   = parallelDataIn & load_mask_s;
                    len_d   = eff_len_s;
                    msb_d   = msbFirst;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // parallelLoad is deliberately not looked at while shifting.
                if (peripheralClkEdge) begin
                    mem_d   = msb_q ? shift_msb_s : shift_lsb_s;
                    cnt_d   = cnt_q + LEN_ONE;
                    state_d = (cnt_q == len_m1_s) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            mem_q   <= MEM_ZERO;
            cnt_q   <= {CW{1'b0}};
            len_q   <= LEN_FULL;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
        end
    end

    assign serialDataOut   = msb_q ? (|(mem_q & msb_sel_s)) : mem_q[0];
    assign parallelDataOut = mem_q;
    assign busy            = (state_q == ST_SHIFT);
    assign done            = (state_q == ST_DONE);

`ifdef SHIFT_RX_HOLD_EN
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_overrun_q, rx_overrun_d;

    // Receive holding register: capture on DONE, flags cleared by acknowledge.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (state_q == ST_DONE) begin
            rx_data_d    = mem_q;
            rx_valid_d   = 1'b1;
            // A coincident ack consumes the old frame, so no overrun is flagged.
            rx_overrun_d = rxAck ? 1'b0 : (rx_overrun_q | rx_valid_q);
        end else if (rxAck) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end else begin
            rx_valid_d   = rx_valid_q;
            rx_overrun_d = rx_overrun_q;
        end
    end

    // Receive holding registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_data_q    <= MEM_ZERO;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rxData    = rx_data_q;
    assign rxValid   = rx_valid_q;
    assign rxOverrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Randomised, scoreboarded bench for spi_shift_engine (WIDTH = 16).
// The driver pushes the transmit bit it expects for every shift edge. At the
// end of each frame it also pushes the expected received word. A negedge
// monitor pops those entries and compares them against serialDataOut and
// parallelDataOut when the DUT shifts or signals done.
// Define SHIFT_RX_HOLD_EN to also exercise the receive holding register.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          resetN;
    logic          peripheralClkEdge;
    logic          parallelLoad;
    logic [W-1:0]  parallelDataIn;
    logic [CW-1:0] frameLen;
    logic          msbFirst;
    logic          serialDataIn;
    logic          serialDataOut;
    logic [W-1:0]  parallelDataOut;
    logic          busy;
    logic          done;
`ifdef SHIFT_RX_HOLD_EN
    logic          rxAck;
    logic [W-1:0]  rxData;
    logic          rxValid;
    logic          rxOverrun;
`endif

    int total = 0;
    int passed = 0;
    int done_seen = 0;
    int frames_done = 0;

    logic         sdo_exp_q [$];
    logic [W-1:0] pdo_exp_q [$];

    spi_shift_engine #(.WIDTH(W), .CW(CW)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .peripheralClkEdge (peripheralClkEdge),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .frameLen          (frameLen),
        .msbFirst          (msbFirst),
        .serialDataIn      (serialDataIn),
`ifdef SHIFT_RX_HOLD_EN
        .rxAck             (rxAck),
        .rxData            (rxData),
        .rxValid           (rxValid),
        .rxOverrun         (rxOverrun),
`endif
        .serialDataOut     (serialDataOut),
        .parallelDataOut   (parallelDataOut),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sdo"},  {63'd0, serialDataOut}, 64'd0);
        chk({tag, "_pdo"},  {48'd0, parallelDataOut}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
`ifdef SHIFT_RX_HOLD_EN
        chk({tag, "_rxdata"},    {48'd0, rxData}, 64'd0);
        chk({tag, "_rxvalid"},   {63'd0, rxValid}, 64'd0);
        chk({tag, "_rxoverrun"}, {63'd0, rxOverrun}, 64'd0);
`endif
    endtask

    // Scoreboard monitor: one transmit bit per taken edge, one word per done pulse.
    always @(negedge clk) begin
        if (resetN && peripheralClkEdge && busy) begin
            if (sdo_exp_q.size() == 0) begin
                total++;
                $display("FAIL sdo_unexpected_shift: actual=%0b required=no shift", serialDataOut);
            end else begin
                chk("sdo_bit", {63'd0, serialDataOut}, {63'd0, sdo_exp_q.pop_front()});
            end
        end
        if (resetN && done) begin
            done_seen++;
            if (pdo_exp_q.size() == 0) begin
                total++;
                $display("FAIL done_unexpected: actual=done pdo 0x%0h required=no done", parallelDataOut);
            end else begin
                chk("frame_pdo", {48'd0, parallelDataOut}, {48'd0, pdo_exp_q.pop_front()});
            end
        end
    end

    // One frame. The expected bits come straight from the bit-order rules:
    // LSB-first sends tx[k] on edge k and rx[k] arrives on edge k.
    // MSB-first sends tx[n-1-k] on edge k and rx[n-1-k] arrives on edge k.
    // abort_at >= 0 applies reset just before that edge instead of finishing.
    task automatic run_frame(input logic [W-1:0] tx, input logic [CW-1:0] flen,
                             input logic msb, input logic [W-1:0] rx, input int abort_at);
        int n;
        logic [W-1:0] mask;
        n = ((flen == 0) || (int'(flen) > W)) ? W : int'(flen);
        mask = '0;
        for (int i = 0; i < n; i++) mask[i] = 1'b1;
        parallelLoad      = 1'b1;
        parallelDataIn    = tx;
        frameLen          = flen;
        msbFirst          = msb;
        peripheralClkEdge = 1'($urandom_range(0, 1));   // must be dropped
        serialDataIn      = 1'($urandom_range(0, 1));
        tick();
        parallelLoad      = 1'b0;
        peripheralClkEdge = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                parallelLoad      = ($urandom_range(0, 3) == 0);
                parallelDataIn    = W'($urandom);
                peripheralClkEdge = 1'b0;
                tick();
            end
            if (k == abort_at) begin
                parallelLoad = 1'b0;
                resetN = 1'b0;
                #1;
                chk_reset_outputs("midframe_reset");
                tick();
                resetN = 1'b1;
                tick();
                chk("after_reset_idle_busy", {63'd0, busy}, 64'd0);
                return;
            end
            peripheralClkEdge = 1'b1;
            serialDataIn      = msb ? rx[n-1-k] : rx[k];
            parallelLoad      = ($urandom_range(0, 1) == 1);   // ignored while shifting
            parallelDataIn    = W'($urandom);
            frameLen          = CW'($urandom);
            msbFirst          = 1'($urandom_range(0, 1));
            sdo_exp_q.push_back(msb ? tx[n-1-k] : tx[k]);
            if (k == n - 1) begin
                pdo_exp_q.push_back(rx & mask);
                frames_done++;
            end
            tick();
        end
        peripheralClkEdge = 1'b0;
        parallelLoad      = 1'b0;
        chk("done_after_len_edges", {63'd0, done}, 64'd1);
        chk("busy_low_in_done", {63'd0, busy}, 64'd0);
    endtask

    // Idle cycles with random edge strobes, which must have no effect.
    task automatic idle(input int cycles);
        repeat (cycles) begin
            parallelLoad      = 1'b0;
            peripheralClkEdge = 1'($urandom_range(0, 1));
            serialDataIn      = 1'($urandom_range(0, 1));
            tick();
        end
        peripheralClkEdge = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN            = 1'b0;
        peripheralClkEdge = 1'b0;
        parallelLoad      = 1'b0;
        parallelDataIn    = '0;
        frameLen          = '0;
        msbFirst          = 1'b0;
        serialDataIn      = 1'b0;
`ifdef SHIFT_RX_HOLD_EN
        rxAck             = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        resetN = 1'b1;
        tick();
        chk_reset_outputs("after_reset");

        // LSB-first full frame, all-ones receive.
        run_frame(16'h00A5, 5'd16, 1'b0, 16'hFFFF, -1);
        chk("lsb_frame_all_ones", {48'd0, parallelDataOut}, 64'hFFFF);
        idle(3);
        chk("idle_busy_low", {63'd0, busy}, 64'd0);
        chk("idle_done_low", {63'd0, done}, 64'd0);

        // MSB-first 8-bit frame.
        run_frame(16'h00B4, 5'd8, 1'b1, 16'h005A, -1);
        chk("msb_frame_5a", {48'd0, parallelDataOut}, 64'h005A);
        idle(2);

        // Length clamping, loaded back-to-back from DONE.
        run_frame(W'($urandom), 5'd0, 1'b0, W'($urandom), -1);
        run_frame(W'($urandom), 5'd20, 1'b1, W'($urandom), -1);
        idle(2);

        // Reset after five edges, then a normal frame.
        run_frame(W'($urandom), 5'd16, 1'b0, W'($urandom), 5);
        run_frame(W'($urandom), 5'd16, 1'b0, W'($urandom), -1);
        idle(2);

        // Randomised frames: any length code, either order, optional back-to-back.
        for (int f = 0; f < 40; f++) begin
            run_frame(W'($urandom), CW'($urandom), 1'($urandom_range(0, 1)), W'($urandom), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

`ifdef SHIFT_RX_HOLD_EN
        rxAck = 1'b1;
        tick();
        rxAck = 1'b0;
        run_frame(W'($urandom), 5'd8, 1'b0, 16'h005A, -1);
        run_frame(W'($urandom), 5'd8, 1'b1, 16'h003C, -1);
        tick();
        chk("rx_data_3c", {48'd0, rxData}, 64'h003C);
        chk("rx_valid_set", {63'd0, rxValid}, 64'd1);
        chk("rx_overrun_set", {63'd0, rxOverrun}, 64'd1);
        rxAck = 1'b1;
        tick();
        rxAck = 1'b0;
        chk("rx_valid_cleared", {63'd0, rxValid}, 64'd0);
        chk("rx_overrun_cleared", {63'd0, rxOverrun}, 64'd0);
        idle(2);
`endif

        chk("sdo_queue_drained", 64'(sdo_exp_q.size()), 64'd0);
        chk("pdo_queue_drained", 64'(pdo_exp_q.size()), 64'd0);
        chk("done_pulse_count", 64'(done_seen), 64'(frames_done));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
